seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexing controller for a 4-digit common-anode seven-segment display. One hex-to-segment decoder is shared across four digit positions. The block sequences digit selection, inserts a blanking gap before each digit to suppress ghosting, and double-buffers the displayed value so an update never tears mid-frame. It sits between the board-level state/datapath logic (state registers, counters) and the display pins.

## Interface

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 4.
- BLANK_CYCLES, 16: cycles at slot start with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value  in  16  four hex nibbles; nibble k (value[4k+3:4k]) drives digit k.
- digit_en  in  4  per-digit enable; 0 keeps that digit dark.
- load  in  1  single-cycle strobe; captures value/digit_en into the pending buffer.
- an  out  4  anode selects, active-low; an[k] low lights digit k.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high; seg[0]=a.
- frame_tick  out  1  one-cycle pulse when slot index wraps 3→0.
- pending  out  1  high while a loaded value waits for the next frame boundary.

## Operation

- Prescaler `div_cnt`, width $clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1 and wraps.
- Slot index `idx` (2 bits) advances on the cycle `div_cnt` wraps: 0→1→2→3→0.
- Within a slot:
  - When `div_cnt` < BLANK_CYCLES: an = 4'b1111, seg = 7'h00.
  - Otherwise, if shadow_en[idx]=1: an[idx] = 0 and seg = decode(shadow_val nibble idx).
  - If shadow_en[idx]=0: the digit stays dark for the whole slot. The slot still consumes REFRESH_DIV cycles.
- Decode table: standard hex glyphs 0–F (e.g. 0→7'h3F, 1→7'h06, 8→7'h7F, A→7'h77, F→7'h71).
- Buffering:
  - `load`=1 writes value/digit_en into the pending registers and sets `pending`=1.
  - A second load before the boundary overwrites the pending data (last load wins).
- Frame boundary is the cycle where `idx`=3 and `div_cnt`=REFRESH_DIV-1. At that edge:
  - If `load` is high the same cycle, the shadow registers take value/digit_en directly and `pending` clears.
  - Else, if `pending`=1, the shadow registers take the pending data and `pending` clears.
  - Otherwise the shadow registers hold.
- The new shadow data is visible starting with digit 0 of the next frame.
- `frame_tick` is a registered output asserted in the first cycle of slot 0 (idx=0, div_cnt=0).
- Reset values: div_cnt=0, idx=0, shadow_val=0, shadow_en=0, pending registers=0, pending=0, an=4'b1111, seg=7'h00, frame_tick=0.
- Reset mid-frame: all outputs return to their reset values immediately (async). Any pending load is discarded.

## Timing

- an and seg are registered: they reflect (idx, div_cnt) one cycle later, so an and seg change on the same edge and never glitch relative to each other.
- Frame period = 4·REFRESH_DIV cycles.
- Each enabled digit is lit for REFRESH_DIV-BLANK_CYCLES cycles per frame.
- Load-to-display latency:
  - Minimum: 1 cycle to the boundary when load coincides with the boundary, plus 1 + BLANK_CYCLES cycles until an[0] falls.
  - Maximum: 4·REFRESH_DIV + BLANK_CYCLES + 1 cycles.
- At most one anode is low in any cycle. During a blank window all anodes are high.

## Structure

- Shared package `seg7_pkg`:
  - NUM_DIGITS=4.
  - SEG_BLANK=7'h00.
  - The 16-entry glyph constant array.
  - Anode-off constant AN_OFF=4'b1111.
- One combinational sub-module `seg7_decoder` (4-bit in, 7-bit seg out), instantiated once and fed by a mux on idx. All sequencing stays in the top.

## Test plan

Parameters for all scenarios: REFRESH_DIV=8, BLANK_CYCLES=2.

- **Reset:** hold reset 3 cycles with random inputs → an=1111, seg=00, frame_tick=0, pending=0. Release → first frame stays dark (shadow_en=0).
- **Basic scan:** load value=16'h1234, digit_en=1111 → after the boundary, an sequence per frame is 1110/1101/1011/0111. seg is 0x66 (4) on digit 0, 0x4F (3) on digit 1, 0x5B (2) on digit 2, 0x06 (1) on digit 3. Each digit is lit 6 cycles after 2 blank cycles; frame_tick fires every 32 cycles.
- **Tear-free update:** load 16'hAAAA at idx=1 → remaining slots still show the old value. pending=1 until the boundary, then every digit shows 0x77 from the next frame.
- **Load on boundary:** assert load with 16'hFFFF exactly at idx=3, div_cnt=7 while a different value is pending → the next frame shows 0x71 on all digits and pending=0.
- **Digit disable:** digit_en=0101, value=16'h8888 → an[1] and an[3] stay high for their entire slots. Digits 0 and 2 show 0x7F; slot length is unchanged.
- **Reset mid-frame:** assert reset at idx=2, div_cnt=4 with pending=1 → outputs go to reset values the same cycle. After release, the pending data is never displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: digit count, blanking
// values and the hex glyph table.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'h00;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    // Segments {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-nibble to seven-segment decoder (active-high segments).
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and a
// double-buffered display value that only swaps at frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick,
    output logic        pending
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_en;
    logic [15:0]      pend_val;
    logic [3:0]       pend_en;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;

    assign slot_end  = (div_cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == 2'd3);
    assign nibble    = shadow_val[{idx, 2'b00} +: 4];

    seg7_decoder u_decoder (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (div_cnt >= BLANK_END && shadow_en[idx]) begin
            an_d[idx] = 1'b0;
            seg_d     = seg_dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            idx        <= 2'd0;
            shadow_val <= '0;
            shadow_en  <= '0;
            pend_val   <= '0;
            pend_en    <= '0;
            pending    <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= slot_end ? '0 : div_cnt + CNT_W'(1);
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            an         <= an_d;
            seg        <= seg_d;
            frame_tick <= frame_end;

            // A load coinciding with the boundary bypasses the pending buffer.
            if (frame_end) begin
                if (load) begin
                    shadow_val <= value;
                    shadow_en  <= digit_en;
                end else if (pending) begin
                    shadow_val <= pend_val;
                    shadow_en  <= pend_en;
                end
                pending <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend_en  <= digit_en;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: cycle-time reference model plus
// directed scenarios and randomized loads.
module tb_seg7_scan_ctrl;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;
    logic        pending;

    int checks   = 0;
    int failures = 0;

    // Model state: cycles since reset release, shadow and pending buffers.
    int          t;
    logic [15:0] m_sv, m_pv;
    logic [3:0]  m_se, m_pe;
    logic        m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_tick;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .digit_en   (digit_en),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        m_sv   = '0;
        m_se   = '0;
        m_pv   = '0;
        m_pe   = '0;
        m_pend = 1'b0;
    endtask

    // One clock: drive inputs, predict the registered outputs, then compare.
    task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] en);
        int pos;
        int slot;
        load     = ld;
        value    = v;
        digit_en = en;
        pos  = t % RD;
        slot = (t / RD) % 4;
        if (pos < BC || !m_se[slot]) begin
            e_an  = 4'b1111;
            e_seg = 7'h00;
        end else begin
            e_an  = ~(4'b0001 << slot);
            e_seg = glyph[m_sv[slot*4 +: 4]];
        end
        e_tick = ((t % FRAME) == FRAME - 1);
        if (e_tick) begin
            if (ld) begin
                m_sv = v;
                m_se = en;
            end else if (m_pend) begin
                m_sv = m_pv;
                m_se = m_pe;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pv   = v;
            m_pe   = en;
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
        check("an", {12'h0, an}, {12'h0, e_an});
        check("seg", {9'h0, seg}, {9'h0, e_seg});
        check("frame_tick", {15'h0, frame_tick}, {15'h0, e_tick});
        check("pending", {15'h0, pending}, {15'h0, m_pend});
        load = 1'b0;
    endtask

    // Idle with random (unloaded) inputs until the model reaches a frame offset.
    task automatic run_to(input int target);
        while ((t % FRAME) != target) begin
            cyc(1'b0, 16'($urandom), 4'($urandom));
        end
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n * FRAME; i++) begin
            cyc(1'b0, 16'($urandom), 4'($urandom));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, {12'h0, an}, 16'h000F);
        check({tag, "_seg"}, {9'h0, seg}, 16'h0000);
        check({tag, "_tick"}, {15'h0, frame_tick}, 16'h0000);
        check({tag, "_pend"}, {15'h0, pending}, 16'h0000);
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'($urandom);
        value    = 16'($urandom);
        digit_en = 4'($urandom);
        model_reset();

        // Reset held for three cycles under random inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_hold");
            load     = 1'($urandom);
            value    = 16'($urandom);
            digit_en = 4'($urandom);
        end
        reset = 1'b0;
        load  = 1'b0;
        model_reset();
        run_frames(1);

        // Basic scan.
        run_to(5);
        cyc(1'b1, 16'h1234, 4'b1111);
        run_to(3);
        check("bs_d0_seg", {9'h0, seg}, 16'h0066);
        check("bs_d0_an", {12'h0, an}, 16'h000E);
        run_to(RD + 3);
        check("bs_d1_seg", {9'h0, seg}, 16'h004F);
        run_to(2 * RD + 3);
        check("bs_d2_seg", {9'h0, seg}, 16'h005B);
        run_to(3 * RD + 3);
        check("bs_d3_seg", {9'h0, seg}, 16'h0006);
        check("bs_d3_an", {12'h0, an}, 16'h0007);
        run_frames(1);

        // Tear-free update loaded during slot 1.
        run_to(RD + 3);
        cyc(1'b1, 16'hAAAA, 4'b1111);
        run_to(2 * RD + 3);
        check("tf_old_seg", {9'h0, seg}, 16'h005B);
        check("tf_pend", {15'h0, pending}, 16'h0001);
        run_to(3);
        check("tf_new_seg", {9'h0, seg}, 16'h0077);
        run_frames(1);

        // Load exactly on the boundary while another value is pending.
        run_to(10);
        cyc(1'b1, 16'h5555, 4'b1111);
        run_to(FRAME - 1);
        cyc(1'b1, 16'hFFFF, 4'b1111);
        check("lb_pend", {15'h0, pending}, 16'h0000);
        run_to(RD + 3);
        check("lb_seg", {9'h0, seg}, 16'h0071);
        run_frames(1);

        // Digits 1 and 3 disabled.
        run_to(4);
        cyc(1'b1, 16'h8888, 4'b0101);
        run_to(3);
        check("dd_d0_seg", {9'h0, seg}, 16'h007F);
        run_to(RD + 5);
        check("dd_d1_an", {12'h0, an}, 16'h000F);
        run_to(2 * RD + 4);
        check("dd_d2_an", {12'h0, an}, 16'h000B);
        run_frames(1);

        // Randomized loads against the model.
        for (int i = 0; i < 6 * FRAME; i++) begin
            cyc(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
        end

        // Reset mid-frame with a load pending.
        run_to(5);
        cyc(1'b1, 16'h0F0F, 4'b1111);
        run_to(2 * RD + 4);
        check("rm_pend_before", {15'h0, pending}, 16'h0001);
        reset = 1'b1;
        #1;
        check_reset_outputs("rm_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rm_hold");
        reset = 1'b0;
        model_reset();
        run_frames(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
